// File: rtl/memorybank_node_table.sv
// Node-information table: MEM_DEPTH words with per-entry valid bits, a live valid count and a max-value scan engine.
// Latency: read data/valid one cycle after rd_index; scan_done lands MEM_DEPTH+1 cycles after scan_start is sampled.
// Backpressure: none; writes are accepted every cycle, and scan_start is dropped while a scan is busy or done.
//
// Ports:
//   clk, nrst                  clock and asynchronous active-low reset
//   wr_en, wr_index, data_in   write strobe and address/data; the write sets the entry's valid bit
//   rd_index -> data_out, rd_valid   registered read of the stored word and its valid bit
//   clr_en                     invalidates every entry and aborts any scan
//   count                      number of valid entries (0..MEM_DEPTH)
//   scan_start -> scan_busy, scan_done, best_found, best_index, best_data   max-value scan
module memorybank_node_table #(
    parameter int WORD_WIDTH = 16,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_index,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] rd_index,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    input  logic                  clr_en,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  scan_start,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic                  best_found,
    output logic [ADDR_WIDTH-1:0] best_index,
    output logic [WORD_WIDTH-1:0] best_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]  valid;

    state_t                state;
    logic [ADDR_WIDTH-1:0] scan_ptr;
    logic                  scan_hit;

    // Data array carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= data_in;
        end
    end

    // Valid bits, count and registered read port. The read samples the array
    // before this edge's write lands, giving read-before-write on a collision.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid    <= '0;
            count    <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            data_out <= mem[rd_index];
            rd_valid <= valid[rd_index];
            if (clr_en) begin
                // Clear first, then let a same-cycle write re-validate its entry.
                valid <= '0;
                if (wr_en) begin
                    valid[wr_index] <= 1'b1;
                    count           <= CNT_ONE;
                end else begin
                    count <= '0;
                end
            end else if (wr_en) begin
                valid[wr_index] <= 1'b1;
                // Only a fresh entry bumps the count, so it tops out at MEM_DEPTH.
                if (!valid[wr_index]) begin
                    count <= count + CNT_ONE;
                end
            end
        end
    end

    // The entry under the pointer wins if it is valid and either nothing has been
    // found yet or it is strictly larger; strictness keeps the lower index on ties.
    always_comb begin
        scan_hit = valid[scan_ptr] && (!best_found || (mem[scan_ptr] > best_data));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            scan_ptr   <= '0;
            scan_busy  <= 1'b0;
            scan_done  <= 1'b0;
            best_found <= 1'b0;
            best_index <= '0;
            best_data  <= '0;
        end else if (clr_en) begin
            // Clear wins over everything, including a scan_start in the same cycle.
            state      <= IDLE;
            scan_ptr   <= '0;
            scan_busy  <= 1'b0;
            scan_done  <= 1'b0;
            best_found <= 1'b0;
            best_index <= '0;
            best_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    scan_done <= 1'b0;
                    if (scan_start) begin
                        state      <= SCAN;
                        scan_ptr   <= '0;
                        scan_busy  <= 1'b1;
                        best_found <= 1'b0;
                        best_index <= '0;
                        best_data  <= '0;
                    end
                end
                SCAN: begin
                    if (scan_hit) begin
                        best_found <= 1'b1;
                        best_index <= scan_ptr;
                        best_data  <= mem[scan_ptr];
                    end
                    if (scan_ptr == LAST_IDX) begin
                        state     <= DONE;
                        scan_busy <= 1'b0;
                        scan_done <= 1'b1;
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    scan_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                    scan_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memorybank_node_table.sv
// Directed bench for memorybank_node_table: reads and scans are scored against a bench-side model of the table.
// Latency: a read result is popped one edge after rd_index is driven; a scan result is popped on scan_done.
// Backpressure: none; the bench drives one operation at a time.
module tb_memorybank_node_table;

    localparam int WW = 16;
    localparam int DEPTH = 64;
    localparam int AW = 6;

    logic          clk;
    logic          nrst;
    logic          wr_en;
    logic [AW-1:0] wr_index;
    logic [WW-1:0] data_in;
    logic [AW-1:0] rd_index;
    logic [WW-1:0] data_out;
    logic          rd_valid;
    logic          clr_en;
    logic [AW:0]   count;
    logic          scan_start;
    logic          scan_busy;
    logic          scan_done;
    logic          best_found;
    logic [AW-1:0] best_index;
    logic [WW-1:0] best_data;

    memorybank_node_table #(.WORD_WIDTH(WW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .data_in    (data_in),
        .rd_index   (rd_index),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .clr_en     (clr_en),
        .count      (count),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .best_found (best_found),
        .best_index (best_index),
        .best_data  (best_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Bench-side model of the table.
    logic [WW-1:0] m_mem [DEPTH];
    bit            m_vld [DEPTH];

    // Scoreboards: read results {data, valid, check_data}, scan results {found, index, data}.
    logic [WW+1:0]    sb_rd [$];
    logic [WW+AW:0]   sb_scan [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m_vld[i]) c++;
        return c;
    endfunction

    task automatic model_best(output logic f, output logic [AW-1:0] bi, output logic [WW-1:0] bd);
        f = 1'b0; bi = '0; bd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && (!f || m_mem[i] > bd)) begin
                f = 1'b1; bi = AW'(i); bd = m_mem[i];
            end
        end
    endtask

    task automatic model_clear_valid();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] idx, input logic [WW-1:0] d);
        wr_en = 1'b1; wr_index = idx; data_in = d;
        step();
        wr_en = 1'b0;
        m_mem[idx] = d;
        m_vld[idx] = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] idx, input bit chk_data);
        logic [WW+1:0] e;
        rd_index = idx;
        sb_rd.push_back({m_mem[idx], m_vld[idx], chk_data});
        step();
        e = sb_rd.pop_front();
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'(e[1]));
        if (e[0]) check({tag, "_data_out"}, 32'(data_out), 32'(e[WW+1:2]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},      32'(count),      32'd0);
        check({tag, "_data_out"},   32'(data_out),   32'd0);
        check({tag, "_rd_valid"},   32'(rd_valid),   32'd0);
        check({tag, "_scan_busy"},  32'(scan_busy),  32'd0);
        check({tag, "_scan_done"},  32'(scan_done),  32'd0);
        check({tag, "_best_found"}, 32'(best_found), 32'd0);
        check({tag, "_best_index"}, 32'(best_index), 32'd0);
        check({tag, "_best_data"},  32'(best_data),  32'd0);
    endtask

    // Count done pulses over a window to prove no (further) scan_done appears.
    task automatic expect_no_done(input string tag, input int cycles);
        int dones = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (scan_done) dones++;
        end
        check({tag, "_no_done"}, 32'(dones), 32'd0);
    endtask

    task automatic run_scan(input string tag, input bit extra_start);
        logic          f;
        logic [AW-1:0] bi;
        logic [WW-1:0] bd;
        logic [WW+AW:0] e;
        int edges;
        int busy_cyc;
        bit got;
        model_best(f, bi, bd);
        sb_scan.push_back({f, bi, bd});
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        edges = 1; busy_cyc = 0; got = 1'b0;
        while (!got && edges < 200) begin
            if (scan_busy) busy_cyc++;
            if (scan_done) begin
                got = 1'b1;
            end else begin
                if (extra_start && edges == 10) scan_start = 1'b1;
                step();
                scan_start = 1'b0;
                edges++;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        e = sb_scan.pop_front();
        if (got) begin
            check({tag, "_done_latency"}, 32'(edges), 32'(DEPTH + 1));
            check({tag, "_busy_cycles"},  32'(busy_cyc), 32'(DEPTH));
            check({tag, "_busy_at_done"}, 32'(scan_busy), 32'd0);
            check({tag, "_best_found"},   32'(best_found), 32'(e[WW+AW]));
            check({tag, "_best_index"},   32'(best_index), 32'(e[WW+AW-1:WW]));
            check({tag, "_best_data"},    32'(best_data),  32'(e[WW-1:0]));
            step();
            check({tag, "_done_one_cycle"}, 32'(scan_done), 32'd0);
            check({tag, "_best_hold"},      32'(best_data), 32'(e[WW-1:0]));
            if (extra_start) expect_no_done(tag, DEPTH + 6);
        end
    endtask

    initial begin
        nrst = 1'b0; wr_en = 1'b0; wr_index = '0; data_in = '0;
        rd_index = '0; clr_en = 1'b0; scan_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b0;
        end
        #12;
        check_all_zero("reset");
        #5 nrst = 1'b1;
        step();

        // Single write then read back; untouched entry reads invalid.
        wr(6'd0, 16'd3);
        rd("w0", 6'd0, 1'b1);
        check("w0_count", 32'(count), 32'(model_count()));
        rd("r1_invalid", 6'd1, 1'b0);

        // Repeat write must not bump the count; tie keeps the lower index.
        wr(6'd1, 16'd15);
        wr(6'd1, 16'd15);
        check("rewrite_count", 32'(count), 32'd2);
        wr(6'd5, 16'd15);
        check("idx5_count", 32'(count), 32'd3);
        run_scan("scan_tie", 1'b0);

        // Full-scale value at the last index.
        wr(6'd63, 16'hFFFF);
        wr(6'd10, 16'd7);
        run_scan("scan_max", 1'b0);

        // Read-before-write on a same-cycle collision.
        rd_index = 6'd10; wr_en = 1'b1; wr_index = 6'd10; data_in = 16'h1234;
        sb_rd.push_back({m_mem[10], m_vld[10], 1'b1});
        step();
        wr_en = 1'b0;
        m_mem[10] = 16'h1234;
        begin
            logic [WW+1:0] e;
            e = sb_rd.pop_front();
            check("rbw_data", 32'(data_out), 32'(e[WW+1:2]));
        end
        rd("rbw_after", 6'd10, 1'b1);

        // Empty table after reset; a second start while busy is ignored.
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        model_clear_valid();
        step();
        check("empty_count", 32'(count), 32'd0);
        run_scan("scan_empty", 1'b1);

        // Clear together with a write leaves only the written entry.
        wr(6'd0, 16'd1);
        wr(6'd1, 16'd2);
        wr(6'd2, 16'd3);
        wr(6'd3, 16'd4);
        check("fill4_count", 32'(count), 32'd4);
        clr_en = 1'b1; wr_en = 1'b1; wr_index = 6'd2; data_in = 16'd9;
        step();
        clr_en = 1'b0; wr_en = 1'b0;
        model_clear_valid();
        m_mem[2] = 16'd9; m_vld[2] = 1'b1;
        check("clrwr_count", 32'(count), 32'd1);
        rd("clrwr_idx2", 6'd2, 1'b1);
        rd("clrwr_idx0", 6'd0, 1'b1);

        // Clear in the middle of a scan aborts it without a done pulse.
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("midclr_busy_before", 32'(scan_busy), 32'd1);
        clr_en = 1'b1;
        step();
        clr_en = 1'b0;
        model_clear_valid();
        check("midclr_busy",       32'(scan_busy),  32'd0);
        check("midclr_best_found", 32'(best_found), 32'd0);
        check("midclr_best_data",  32'(best_data),  32'd0);
        check("midclr_count",      32'(count),      32'd0);
        expect_no_done("midclr", DEPTH + 6);

        // Asynchronous reset between edges in the middle of a scan.
        wr(6'd4, 16'h0055);
        rd("pre_arst", 6'd4, 1'b1);
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2;
        nrst = 1'b0;
        #1;
        check_all_zero("arst");
        #3;
        nrst = 1'b1;
        model_clear_valid();
        step();
        rd("post_arst_idx4", 6'd4, 1'b1);
        check("post_arst_busy", 32'(scan_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/memorybank_node_table.md
Name: memorybank_node_table

Overview:
- Parametrised successor to the single-port node memory bank.
- Holds up to MEM_DEPTH node-information words, each with a per-entry valid bit, and keeps a running count of valid entries.
- Has a registered read port and a bulk clear.
- A sequential scan engine walks all valid entries and reports the one with the largest value. Routing logic uses it to pick the best next-hop entry.

Parameters:
- WORD_WIDTH, 16, width of each stored word (unsigned).
- MEM_DEPTH, 64, number of entries.
- ADDR_WIDTH, 6, index width; must equal clog2(MEM_DEPTH).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- nrst  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe; one write per asserted cycle.
- wr_index  input  ADDR_WIDTH  write address.
- data_in  input  WORD_WIDTH  write data.
- rd_index  input  ADDR_WIDTH  read address.
- data_out  output  WORD_WIDTH  registered read data.
- rd_valid  output  1  registered valid bit of the entry read.
- clr_en  input  1  invalidate all entries; aborts any scan.
- count  output  ADDR_WIDTH+1  number of valid entries.
- scan_start  input  1  start a max-value scan.
- scan_busy  output  1  scan in progress.
- scan_done  output  1  one-cycle pulse when a scan result is ready.
- best_found  output  1  at least one valid entry existed during the last completed scan.
- best_index  output  ADDR_WIDTH  index of the maximum entry.
- best_data  output  WORD_WIDTH  value of the maximum entry.

Behaviour:
- Reset (nrst low, asynchronous):
  - All valid bits, count, data_out, rd_valid, scan_busy, scan_done, best_found, best_index and best_data go to 0.
  - FSM goes to IDLE.
  - Data array contents are not reset.
- Write: on a clk edge with wr_en=1, mem[wr_index] takes data_in and valid[wr_index] is set.
  - count increments only if the entry was previously invalid.
  - A rewrite of a valid entry leaves count unchanged.
- Read: data_out and rd_valid reflect mem[rd_index] and valid[rd_index] one cycle after rd_index is presented.
  - Read of an invalid entry returns its stored data with rd_valid=0.
  - Read and write to the same index in the same cycle returns the old data (read-before-write).
- Clear: clr_en=1 zeroes all valid bits and count.
  - clr_en and wr_en in the same cycle: clear applies first, then the write. Result: only wr_index is valid and count=1.
- count saturates naturally at MEM_DEPTH; it never wraps.
- FSM states IDLE, SCAN, DONE:
  - IDLE: scan_start=1 goes to SCAN. The scan pointer and best registers are zeroed and best_found is cleared.
  - SCAN: scan_busy=1. One entry is examined per cycle, pointer 0 to MEM_DEPTH-1. A valid entry whose value is strictly greater than the current best, or the first valid entry seen, updates best_index, best_data and best_found. Ties keep the lower index. After the entry at MEM_DEPTH-1 is examined, the FSM goes to DONE.
  - DONE: scan_done=1 for exactly one cycle, scan_busy=0, then back to IDLE.
- Scan timing:
  - scan_start sampled at edge N gives scan_busy high for cycles N+1 to N+MEM_DEPTH and scan_done high in cycle N+MEM_DEPTH+1.
  - best_* outputs hold their values after DONE until the next scan_start or clr_en.
- scan_start while in SCAN or DONE is ignored.
- Writes during a scan are allowed. An entry is compared using its contents at the cycle the pointer reaches it, so writes behind the pointer are not reflected.
- clr_en during SCAN or DONE aborts to IDLE with no scan_done pulse; best_found=0 and best_* are zeroed.
- An empty table gives scan_done with best_found=0, best_index=0 and best_data=0.
- Unsigned comparison over the full WORD_WIDTH.

Test Plan:
- Reset, then write index 0 data 3, then read index 0 -> next cycle data_out=3, rd_valid=1, count=1; read index 1 -> rd_valid=0.
- Write index 1 data 15 twice, then index 5 data 15 -> count=2 after the repeat write, count=3 after index 5; scan -> best_index=1, best_data=15 (tie keeps the lower index), scan_done exactly 65 cycles after scan_start.
- Write index 63 data 16'hFFFF and index 10 data 7, then scan -> best_index=63, best_data=FFFF, best_found=1; scan_busy high 64 cycles.
- Empty table after reset, then scan -> scan_done with best_found=0, best_index=0, best_data=0; a second scan_start while busy is ignored (still a single done pulse).
- Fill 4 entries, assert clr_en together with wr_en at index 2 data 9 -> count=1, only index 2 valid; clr_en mid-scan -> FSM back to IDLE, no scan_done, best_found=0.
- Assert nrst low asynchronously mid-scan (between clock edges) -> all outputs 0 immediately; after release, read of a previously written index gives rd_valid=0.
